// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the default datapath width.
package md_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_CALC = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

endpackage

// File: rtl/md_iter_core.sv
// Unsigned one-bit-per-step datapath: right-shifting shift-add multiply and
// left-shifting restoring divide, sharing the {acc, mq} register pair.
module md_iter_core
  import md_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] mq_init,
  input  logic [DATA_W-1:0] b_init,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] mq,
  output logic              last
);

  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] b_reg;
  logic [CW-1:0]     cnt;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              fits;

  // mq holds the multiplier (mul) or the dividend bits still to shift in (div).
  always_comb begin
    add_sum = {1'b0, acc} + (mq[0] ? {1'b0, b_reg} : '0);
    shifted = {acc, mq[DATA_W-1]};
    fits    = shifted >= {1'b0, b_reg};
    diff    = shifted[DATA_W-1:0] - b_reg;
  end

  assign last = (cnt == CW'(DATA_W - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mq    <= '0;
      b_reg <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      mq    <= mq_init;
      b_reg <= b_init;
      cnt   <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        acc <= fits ? diff : shifted[DATA_W-1:0];
        mq  <= {mq[DATA_W-2:0], fits};
      end else begin
        {acc, mq} <= {add_sum, mq[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: FSM, operand sign handling, HI/LO registers and
// the busy/done handshake around the iterative core.
module muldiv_unit
  import md_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MD_start,
  input  logic [2:0]        MD_op,
  input  logic [DATA_W-1:0] MD_data_in1,
  input  logic [DATA_W-1:0] MD_data_in2,
  input  logic              MD_flush,
  output logic              MD_busy,
  output logic              MD_done,
  output logic [DATA_W-1:0] MD_hi,
  output logic [DATA_W-1:0] MD_lo
);

  logic [1:0]        state;
  logic              op_div, op_signed, neg_q, neg_r;
  logic [DATA_W-1:0] op_a, op_b, hi_r, lo_r;
  logic              done_r;

  logic              s1, s2;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [DATA_W-1:0] acc, mq;
  logic              last;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0] quo_fix, rem_fix;

  always_comb begin
    s1       = op_signed & op_a[DATA_W-1];
    s2       = op_signed & op_b[DATA_W-1];
    mag_a    = s1 ? -op_a : op_a;
    mag_b    = s2 ? -op_b : op_b;
    prod     = {acc, mq};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -mq : mq;
    rem_fix  = neg_r ? -acc : acc;
  end

  md_iter_core #(.DATA_W(DATA_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state == ST_PREP),
    .step    ((state == ST_CALC) && !MD_flush),
    .is_div  (op_div),
    .mq_init (op_div ? mag_a : mag_b),
    .b_init  (op_div ? mag_b : mag_a),
    .acc     (acc),
    .mq      (mq),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (MD_flush && state != ST_IDLE) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            // A flush in the same cycle cancels the request.
            if (MD_start && !MD_flush) begin
              if (MD_op == OP_MTHI) begin
                hi_r <= MD_data_in1;
              end else if (MD_op == OP_MTLO) begin
                lo_r <= MD_data_in1;
              end else if (!MD_op[2]) begin
                op_div    <= MD_op[1];
                op_signed <= ~MD_op[0];
                op_a      <= MD_data_in1;
                op_b      <= MD_data_in2;
                state     <= ST_PREP;
              end
            end
          end
          ST_PREP: begin
            neg_q <= s1 ^ s2;
            neg_r <= s1;
            state <= ST_CALC;
          end
          ST_CALC: begin
            if (last) state <= ST_FIX;
          end
          default: begin
            if (!op_div) begin
              {hi_r, lo_r} <= prod_fix;
            end else if (op_b == '0) begin
              hi_r <= op_a;
              lo_r <= '1;
            end else begin
              hi_r <= rem_fix;
              lo_r <= quo_fix;
            end
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign MD_busy = (state != ST_IDLE);
  assign MD_done = done_r;
  assign MD_hi   = hi_r;
  assign MD_lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pushed at issue time from a
// behavioural model, popped and compared whenever MD_done pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MD_start = 1'b0;
  logic [2:0]  MD_op = 3'b000;
  logic [31:0] MD_data_in1 = '0;
  logic [31:0] MD_data_in2 = '0;
  logic        MD_flush = 1'b0;
  logic        MD_busy, MD_done;
  logic [31:0] MD_hi, MD_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  muldiv_unit #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MD_start    (MD_start),
    .MD_op       (MD_op),
    .MD_data_in1 (MD_data_in1),
    .MD_data_in2 (MD_data_in2),
    .MD_flush    (MD_flush),
    .MD_busy     (MD_busy),
    .MD_done     (MD_done),
    .MD_hi       (MD_hi),
    .MD_lo       (MD_lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64;
    int qa, qb, q, r;
    logic [63:0] res;
    res = '0;
    case (op)
      3'b000: begin
        sa = $signed(a);
        sb64 = $signed(b);
        res = sa * sb64;
      end
      3'b001: res = {32'b0, a} * {32'b0, b};
      3'b010: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          qa = a;
          qb = b;
          q = qa / qb;
          r = qa % qb;
          res = {r, q};
        end
      end
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && MD_done === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: MD_done=1 with no op outstanding (hi=%h lo=%h)", MD_hi, MD_lo);
      end else begin
        e = sb.pop_front();
        if (MD_hi !== e.hi || MD_lo !== e.lo) begin
          fails++;
          $display("FAIL %s: hi=%h lo=%h, expected hi=%h lo=%h", e.name, MD_hi, MD_lo, e.hi, e.lo);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input string name);
    logic [63:0] m;
    @(negedge clk);
    MD_start = 1'b1;
    MD_op = op;
    MD_data_in1 = a;
    MD_data_in2 = b;
    if (push) begin
      m = model(op, a, b);
      sb.push_back('{hi: m[63:32], lo: m[31:0], name: name});
    end
    @(posedge clk);
    #1 MD_start = 1'b0;
  endtask

  // Entered just after the start edge (plus any cycles already spent).
  task automatic wait_done(input string name, input int already);
    int cycles;
    cycles = already;
    tests++;
    if (MD_busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy_start: busy=%b, expected 1", name, MD_busy);
    end
    while (MD_done !== 1'b1 && cycles < 60) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    tests++;
    if (cycles !== 34) begin
      fails++;
      $display("FAIL %s_latency: %0d cycles, expected 34", name, cycles);
    end
    tests++;
    if (MD_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy_end: busy=%b, expected 0", name, MD_busy);
    end
    @(negedge clk);
    tests++;
    if (MD_done !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_pulse: done=%b one cycle later, expected 0", name, MD_done);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (MD_hi !== 32'h0 || MD_lo !== 32'h0 || MD_busy !== 1'b0 || MD_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, expected all 0", MD_hi, MD_lo, MD_busy, MD_done);
    end
    #10 rst_n = 1'b1;
  endtask

  task automatic test_mult();
    issue(3'b000, 32'hFFFF_FFFD, 32'd5, 1, "mult_neg3x5");
    wait_done("mult_neg3x5", 0);
  endtask

  task automatic test_multu_div();
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "multu_max");
    wait_done("multu_max", 0);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1, "div_neg7by2");
    wait_done("div_neg7by2", 0);
  endtask

  task automatic test_div_corners();
    issue(3'b011, 32'd7, 32'd0, 1, "divu_by_zero");
    wait_done("divu_by_zero", 0);
    issue(3'b010, 32'hFFFF_FFF9, 32'd0, 1, "div_by_zero");
    wait_done("div_by_zero", 0);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_overflow");
    wait_done("div_overflow", 0);
  endtask

  task automatic test_mthi_mtlo();
    // Previous op left HI=0, LO=0x80000000.
    issue(3'b100, 32'h1234_5678, 32'h0, 0, "");
    tests++;
    if (MD_hi !== 32'h1234_5678 || MD_lo !== 32'h8000_0000 || MD_busy !== 1'b0) begin
      fails++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b, expected hi=12345678 lo=80000000 busy=0", MD_hi, MD_lo, MD_busy);
    end
    issue(3'b101, 32'hCAFE_F00D, 32'h0, 0, "");
    tests++;
    if (MD_hi !== 32'h1234_5678 || MD_lo !== 32'hCAFE_F00D || MD_busy !== 1'b0) begin
      fails++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b, expected hi=12345678 lo=cafef00d busy=0", MD_hi, MD_lo, MD_busy);
    end
  endtask

  task automatic test_mtlo_while_busy();
    issue(3'b000, 32'd3, 32'd4, 1, "mult_with_ignored_mtlo");
    @(negedge clk);
    MD_start = 1'b1;
    MD_op = 3'b101;
    MD_data_in1 = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 MD_start = 1'b0;
    wait_done("mult_with_ignored_mtlo", 1);
  endtask

  task automatic test_flush();
    logic [63:0] m;
    issue(3'b100, 32'hAAAA_5555, 32'h0, 0, "");
    issue(3'b101, 32'h1234_ABCD, 32'h0, 0, "");
    issue(3'b000, 32'd6, 32'd7, 0, "");
    repeat (9) @(posedge clk);
    @(negedge clk);
    MD_flush = 1'b1;
    @(posedge clk);
    #1 MD_flush = 1'b0;
    MD_start = 1'b1;
    MD_op = 3'b000;
    MD_data_in1 = 32'd6;
    MD_data_in2 = 32'd7;
    m = model(3'b000, 32'd6, 32'd7);
    sb.push_back('{hi: m[63:32], lo: m[31:0], name: "mult_after_flush"});
    tests++;
    if (MD_busy !== 1'b0 || MD_hi !== 32'hAAAA_5555 || MD_lo !== 32'h1234_ABCD) begin
      fails++;
      $display("FAIL flush: busy=%b hi=%h lo=%h, expected busy=0 hi=aaaa5555 lo=1234abcd", MD_busy, MD_hi, MD_lo);
    end
    @(posedge clk);
    #1 MD_start = 1'b0;
    wait_done("mult_after_flush", 0);
  endtask

  task automatic test_reset_mid_op();
    bit done_seen;
    issue(3'b011, 32'd100, 32'd3, 0, "");
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (MD_hi !== 32'h0 || MD_lo !== 32'h0 || MD_busy !== 1'b0 || MD_done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b, expected all 0", MD_hi, MD_lo, MD_busy, MD_done);
    end
    #10 rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (MD_done === 1'b1) done_seen = 1'b1;
    end
    tests++;
    if (done_seen !== 1'b0 || MD_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_done: done_seen=%b busy=%b, expected 0 0", done_seen, MD_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i % 2 == 1) b = -b;
      issue(op, a, b, 1, $sformatf("rand%0d_op%0d", i, op));
      wait_done($sformatf("rand%0d", i), 0);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_div();
    test_div_corners();
    test_mthi_mtlo();
    test_mtlo_while_busy();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results never produced, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run so far", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
